sobel_output_aligner: RTL and testbench

//  Downstream stage of the Sobel edge pipeline. Samples the Sobel result byte, strips the

---
 rtl/sobel_output_aligner.sv | 156 +++++++++++++++
 tb/tb_sobel_output_aligner.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sobel_output_aligner.sv
// Aligns Sobel results to their centre-pixel coordinates, drops the pipeline warm-up,
// forces border pixels to a constant and buffers tagged results in a small output FIFO.
//
// state  | meaning
// IDLE   | waiting for the first sample after reset/clear
// WARMUP | discarding the first LATENCY samples
// STREAM | every sample is a result for the current (x,y)
module sobel_output_aligner #(
    parameter int          WIDTH        = 512,
    parameter int          HEIGHT       = 512,
    parameter int          LATENCY      = WIDTH + 7,
    parameter int          X_W          = 10,
    parameter int          Y_W          = 10,
    parameter logic [7:0]  BORDER_VALUE = 8'hFF,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     sobel_data,
    input  logic           data_en,
    input  logic           clear,
    output logic [7:0]     out_data,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic           out_sof,
    output logic           out_eol,
    output logic           out_eof,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           overflow
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int WCW = $clog2(LATENCY + 1);
    localparam int EW  = 8 + X_W + Y_W + 3;

    typedef enum logic [1:0] {IDLE, WARMUP, STREAM} state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] warm_cnt, warm_nxt;
    logic           en_d;
    logic           sample;
    logic           push_req;

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           at_xmax, at_ymax, border;
    logic [EW-1:0]  entry;

    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, pop, push_ok, drop;

    // sobel_data is valid the cycle after data_en, so en_d marks a sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      en_d <= 1'b0;
        else if (clear) en_d <= 1'b0;
        else            en_d <= data_en;
    end

    assign sample = en_d & ~clear;

    always_comb begin
        state_nxt = state;
        warm_nxt  = warm_cnt;
        push_req  = 1'b0;
        case (state)
            IDLE: begin
                if (sample) begin
                    warm_nxt  = WCW'(1);
                    state_nxt = (LATENCY == 1) ? STREAM : WARMUP;
                end
            end
            WARMUP: begin
                if (sample) begin
                    if (warm_cnt == WCW'(LATENCY - 1)) state_nxt = STREAM;
                    else                               warm_nxt  = warm_cnt + WCW'(1);
                end
            end
            STREAM:  push_req = sample;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            warm_cnt <= '0;
        end else if (clear) begin
            state    <= IDLE;
            warm_cnt <= '0;
        end else begin
            state    <= state_nxt;
            warm_cnt <= warm_nxt;
        end
    end

    assign at_xmax = (x == X_W'(WIDTH - 1));
    assign at_ymax = (y == Y_W'(HEIGHT - 1));
    assign border  = (x == '0) | at_xmax | (y == '0) | at_ymax;
    assign entry   = {border ? BORDER_VALUE : sobel_data, x, y,
                      (x == '0) & (y == '0), at_xmax, at_xmax & at_ymax};

    // coordinates advance on every stream sample, even a dropped one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (push_req) begin
            if (at_xmax) begin
                x <= '0;
                y <= at_ymax ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

    assign out_valid = (count != '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready & ~clear;
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok & ~pop)      count <= count + CW'(1);
            else if (pop & ~push_ok) count <= count - CW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    assign {out_data, out_x, out_y, out_sof, out_eol, out_eof} = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_sobel_output_aligner.sv
// Scoreboard bench for sobel_output_aligner on an 8x4 image with a 15-sample warm-up.
module tb_sobel_output_aligner;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int L  = 15;
    localparam int XW = 4;
    localparam int YW = 3;
    localparam int EW = 8 + XW + YW + 3;

    logic          clk, reset, data_en, clear, out_ready;
    logic [7:0]    sobel_data, out_data;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_sof, out_eol, out_eof, out_valid, overflow;

    sobel_output_aligner #(
        .WIDTH(W), .HEIGHT(H), .LATENCY(L), .X_W(XW), .Y_W(YW),
        .BORDER_VALUE(8'hFF), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .sobel_data(sobel_data), .data_en(data_en),
        .clear(clear), .out_data(out_data), .out_x(out_x), .out_y(out_y),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] sb[$];
    int warm, mx, my;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // one enable, then the data byte the following cycle; expected entry goes to the scoreboard
    task automatic send(input logic [7:0] d, input bit drop, input bit rdy_at_sample);
        logic [7:0] ed;
        bit brd, sof, eol, eof;
        @(negedge clk);
        data_en = 1'b1;
        @(negedge clk);
        data_en    = 1'b0;
        sobel_data = d;
        if (rdy_at_sample) out_ready = 1'b1;
        if (warm < L) begin
            warm++;
        end else begin
            brd = (mx == 0) || (mx == W-1) || (my == 0) || (my == H-1);
            ed  = brd ? 8'hFF : d;
            sof = (mx == 0) && (my == 0);
            eol = (mx == W-1);
            eof = eol && (my == H-1);
            if (!drop) sb.push_back({ed, XW'(mx), YW'(my), sof, eol, eof});
            if (mx == W-1) begin
                mx = 0;
                my = (my == H-1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // monitor: an accepted head is compared against the oldest expected entry
    initial begin
        logic [EW-1:0] expv;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready && !clear) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output actual=x%0d,y%0d required=none", out_x, out_y);
                end else begin
                    expv = sb.pop_front();
                    check("stream_entry",
                          32'({out_data, out_x, out_y, out_sof, out_eol, out_eof}), 32'(expv));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; clear = 1'b0; data_en = 1'b0; sobel_data = 8'h00; out_ready = 1'b1;
        warm = 0; mx = 0; my = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        check("rst_data",     32'(out_data),  32'd0);
        check("rst_xy",       32'({out_x, out_y}), 32'd0);
        check("rst_flags",    32'({out_sof, out_eol, out_eof}), 32'd0);

        for (int i = 0; i < L; i++) send(8'(i + 1), 1'b0, 1'b0);
        @(negedge clk); #1;
        check("warmup_valid", 32'(out_valid), 32'd0);

        send(8'h33, 1'b0, 1'b0);
        @(negedge clk); #1;
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_xy",    32'({out_x, out_y}), 32'd0);
        check("first_sof",   32'(out_sof), 32'd1);
        check("first_data",  32'(out_data), 32'hFF);

        // ramp over the rest of the frame; index 19 is (3,2)
        for (int s = 1; s < 32; s++) send((s == 19) ? 8'h5A : 8'(8'h20 + s), 1'b0, 1'b0);
        send(8'h77, 1'b0, 1'b0);
        wait_drain();

        // backpressure: four fill the FIFO, the fifth is dropped
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(8'h81 + i), (i == 4), 1'b0);
        @(negedge clk); #1;
        check("bp_overflow", 32'(overflow),  32'd1);
        check("bp_valid",    32'(out_valid), 32'd1);
        check("bp_head_x",   32'(out_x),     32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain();
        send(8'h90, 1'b0, 1'b0);
        @(negedge clk); #1;
        check("bp_next_x", 32'(out_x), 32'd6);

        for (int i = 0; i < 40 && !(mx == 2 && my == 2); i++) send(8'(8'h40 + mx), 1'b0, 1'b0);
        wait_drain();
        out_ready = 1'b0;
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_clear_pos", 32'({mx[3:0], my[3:0]}), 32'h42);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("clear_valid",    32'(out_valid), 32'd0);
        check("clear_overflow", 32'(overflow),  32'd0);
        sb.delete();
        warm = 0; mx = 0; my = 0;

        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < L; i++) send(8'(8'hB0 + i), 1'b0, 1'b0);
        @(negedge clk); #1;
        check("rewarm_valid", 32'(out_valid), 32'd0);
        send(8'h55, 1'b0, 1'b0);
        wait_drain();

        // full FIFO with a pop in the same cycle as a new sample
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'hC1 + i), 1'b0, 1'b0);
        send(8'hC5, 1'b0, 1'b1);
        @(negedge clk); #1;
        check("fwp_overflow", 32'(overflow), 32'd0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
